// File: rtl/lock_disp_pkg.sv
// Shared types and segment constants for the lock display stage.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package lock_disp_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        BLINK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Packed HEX5..HEX0, HEX5 in the most significant 7 bits.
    localparam logic [41:0] MSG_OPEN   = {SEG_BLANK, SEG_BLANK, SEG_O, SEG_P, SEG_E, SEG_N};
    localparam logic [41:0] MSG_CLOSED = {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_D};
    localparam logic [41:0] ALL_BLANK  = {6{SEG_BLANK}};

endpackage

// File: rtl/seg7_digit_enc.sv
// 4-bit digit to active-low 7-segment pattern; values above 9 show "E".
module seg7_digit_enc
    import lock_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/lock_display_ctrl.sv
// Scrolling digit history and blinking OPEn/CLOSEd verdict on HEX0..HEX5.
// Define LOCK_DISPLAY_MASK_DIGITS_EN to show entered digits as dashes.
module lock_display_ctrl
    import lock_disp_pkg::*;
#(
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int NUM_BLINKS   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       result_valid,
    input  logic       result_open,
    input  logic       clear,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       busy
);

    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int TW = $clog2(2*NUM_BLINKS+1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES-1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2*NUM_BLINKS);

    state_t        state_q, state_n;
    logic [41:0]   hist_q, hist_n;
    logic          res_open_q, res_open_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] tog_q, tog_n;
    logic          vis_q, vis_n;
    logic [41:0]   hex_q, hex_n;
    logic          busy_q, busy_n;
    logic [41:0]   msg;
    logic [6:0]    enc_seg;
    logic [6:0]    digit_seg;

    seg7_digit_enc u_enc (
        .digit (digit),
        .seg   (enc_seg)
    );

`ifdef LOCK_DISPLAY_MASK_DIGITS_EN
    assign digit_seg = SEG_DASH;
`else
    assign digit_seg = enc_seg;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ENTRY;
            hist_q     <= ALL_BLANK;
            res_open_q <= 1'b0;
            cnt_q      <= '0;
            tog_q      <= '0;
            vis_q      <= 1'b1;
            hex_q      <= ALL_BLANK;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            hist_q     <= hist_n;
            res_open_q <= res_open_n;
            cnt_q      <= cnt_n;
            tog_q      <= tog_n;
            vis_q      <= vis_n;
            hex_q      <= hex_n;
            busy_q     <= busy_n;
        end
    end

    // Next-state: clear > result_valid > digit_valid > blink timing.
    always_comb begin
        state_n    = state_q;
        hist_n     = hist_q;
        res_open_n = res_open_q;
        cnt_n      = cnt_q;
        tog_n      = tog_q;
        vis_n      = vis_q;
        if (clear) begin
            state_n = ENTRY;
            hist_n  = ALL_BLANK;
            cnt_n   = '0;
            tog_n   = '0;
            vis_n   = 1'b1;
        end else if (result_valid) begin
            state_n    = BLINK;
            res_open_n = result_open;
            cnt_n      = '0;
            tog_n      = '0;
            vis_n      = 1'b1;
        end else if (digit_valid) begin
            if (state_q == ENTRY) begin
                hist_n = {hist_q[34:0], digit_seg};
            end else begin
                hist_n  = {{5{SEG_BLANK}}, digit_seg};
                state_n = ENTRY;
            end
        end else if (state_q == BLINK) begin
            if (cnt_q == CNT_LAST) begin
                cnt_n = '0;
                tog_n = tog_q + 1'b1;
                vis_n = ~vis_q;
                // Last toggle lands on the visible phase and parks there.
                if (tog_n == TOG_LAST) begin
                    state_n = HOLD;
                    vis_n   = 1'b1;
                end
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    // Outputs are derived from next-state so they register alongside it.
    always_comb begin
        msg    = res_open_n ? MSG_OPEN : MSG_CLOSED;
        hex_n  = hist_n;
        busy_n = 1'b0;
        case (state_n)
            ENTRY: hex_n = hist_n;
            BLINK: begin
                hex_n  = vis_n ? msg : ALL_BLANK;
                busy_n = 1'b1;
            end
            HOLD:    hex_n = msg;
            default: hex_n = ALL_BLANK;
        endcase
    end

    assign HEX5 = hex_q[41:35];
    assign HEX4 = hex_q[34:28];
    assign HEX3 = hex_q[27:21];
    assign HEX2 = hex_q[20:14];
    assign HEX1 = hex_q[13:7];
    assign HEX0 = hex_q[6:0];
    assign busy = busy_q;

endmodule

// File: doc/lock_display_ctrl.md
Name: lock_display_ctrl

Overview:
- Display stage directly downstream of the combination-lock FSM.
- Consumes per-digit entry pulses and the final open/closed verdict from the lock.
- Drives the six active-low 7-segment displays HEX0..HEX5 on the DE1-SoC.
- Keeps a scrolling history of entered digits; on a verdict, blinks "OPEn" or "CLOSEd" a fixed number of times, then holds it steady.

Parameters:
- BLINK_CYCLES, 25_000_000: clock cycles per blink phase (message on or off).
- NUM_BLINKS, 3: number of off/on blink pairs before the message holds steady.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- digit_valid  in  1  one-cycle pulse; digit is accepted this cycle
- digit  in  4  entered digit value
- result_valid  in  1  one-cycle pulse; lock verdict is available
- result_open  in  1  1 = unlocked (OPEn), 0 = rejected (CLOSEd); sampled with result_valid
- clear  in  1  return to blank entry display
- HEX0..HEX5  out  7 each  active-low segments, bit order {g,f,e,d,c,b,a}; HEX0 is rightmost
- busy  out  1  high while blinking

Behaviour:
- Single clock domain, fully registered outputs. Reset is synchronous, active-low, and checked on clk edge only.
- On reset:
  - state = ENTRY, history empty, counters 0.
  - All HEX = 7'b1111111 (blank), busy = 0.
  - Reset mid-blink aborts immediately.
- Encodings:
  - 0-9 standard; digit > 9 displays "E" (7'b0000110).
  - O 7'b1000000, P 7'b0001100, E 7'b0000110, n 7'b0101011, C 7'b1000110, L 7'b1000111, S 7'b0010010, d 7'b0100001, blank 7'b1111111.
- States: ENTRY, BLINK, HOLD.
- ENTRY:
  - Each digit_valid shifts history left: HEX5 <= HEX4 ... HEX1 <= HEX0, HEX0 <= enc(digit).
  - Unfilled positions stay blank.
  - A 7th digit drops the oldest value off HEX5.
  - Displays update one cycle after the pulse.
- result_valid in any state:
  - Latch result_open, load the message, reset the phase counter and blink count, go to BLINK, busy = 1.
  - All of these take effect in the next cycle.
  - Messages: open = HEX5..HEX0 {blank, blank, O, P, E, n}; closed = {C, L, O, S, E, d}.
- BLINK:
  - The phase counter counts 0..BLINK_CYCLES-1. At the terminal count, visibility toggles.
  - The first phase is visible, so the message appears immediately.
  - After 2*NUM_BLINKS toggles, go to HOLD with the message visible and busy = 0.
  - Invisible phase drives all HEX blank.
- HOLD: message steady indefinitely.
- digit_valid in BLINK or HOLD: clear history, place the digit on HEX0 with the others blank, go to ENTRY, busy = 0.
- clear (any state): blank all, go to ENTRY, busy = 0.
- Priority when inputs coincide: reset_n > clear > result_valid > digit_valid. A digit coinciding with a result is dropped.
- Counter widths are $clog2(BLINK_CYCLES) and $clog2(2*NUM_BLINKS+1). No wrap occurs beyond the terminal counts.

Optional Feature:
- LOCK_DISPLAY_MASK_DIGITS_EN defined: in ENTRY, each accepted digit displays as a dash (7'b0111111) instead of its value; shifting and count behaviour are unchanged.
- Undefined: digit values are displayed as specified above.

Decomposition:
- Shared package lock_disp_pkg holds:
  - the state enum (ENTRY, BLINK, HOLD);
  - segment constants SEG_0..SEG_9, SEG_O, SEG_P, SEG_E, SEG_N, SEG_C, SEG_L, SEG_S, SEG_D, SEG_BLANK, SEG_DASH;
  - message constants MSG_OPEN and MSG_CLOSED, each 42 bits.
- One combinational sub-module, seg7_digit_enc (4-bit digit -> 7-bit active-low segments), instantiated once on the digit input path.

Test Plan (BLINK_CYCLES=4, NUM_BLINKS=2):
- Reset then idle:
  - reset_n=0 for 2 cycles -> all HEX = 7'b1111111, busy=0.
- Digit entry and scrolling:
  - Pulse digits 1,2,3 -> HEX2,1,0 = enc(1), enc(2), enc(3); HEX5..3 blank.
  - Continue with 4,5,6,7 -> HEX5..HEX0 = enc(2)..enc(7).
- Open verdict:
  - result_valid=1, result_open=1 -> next cycle message {blank, blank, O, P, E, n} and busy=1.
  - Blank for cycles 5-8, visible 9-12, blank 13-16; visible from cycle 17 onward in HOLD with busy=0.
- Closed verdict:
  - result_open=0 -> HEX5..HEX0 = C, L, O, S, E, d.
  - Pulse clear mid-BLINK -> all blank next cycle, busy=0.
- Coincident pulses:
  - digit_valid=1 (digit=9) and result_valid=1 in the same cycle -> message shown, 9 never displayed.
  - Later digit_valid with digit=12 -> HEX0 = "E", others blank, state ENTRY.
- Reset mid-blink:
  - reset_n=0 during BLINK -> next edge all blank, busy=0.
  - A subsequent digit_valid shows on HEX0 only.
